// File: rtl/serial_add_sequencer_pkg.sv
// Shared types and defaults for the bit-serial adder.
// State encodings and default operand width.
package serial_add_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/full_adder_1b.sv
// Single-bit full adder from two half adders.
// Reused every cycle by the serial sequencer.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha1 (
    .a (a),
    .b (b),
    .s (s1),
    .c (c1)
  );

  half_adder u_ha2 (
    .a (s1),
    .b (cin),
    .s (s),
    .c (c2)
  );

  // Either stage may generate the carry
  always_comb cout = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder.
// Building block of the shared full-adder cell.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  // Sum and carry of two bits
  always_comb begin
    s = a ^ b;
    c = a & b;
  end

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder: one full-adder cell, LSB first.
// Optional subtract mode behind SERIAL_SUB_EN.
module serial_add_sequencer
  import serial_add_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SERIAL_SUB_EN
  input  logic             SUB,
`endif
  output logic             READY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             C_OUT
);

  state_t state;
  state_t next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nx;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             s_bit;
  logic             c_bit;
  logic             last;

  full_adder_1b u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (s_bit),
    .cout (c_bit)
  );

  // Result shift register after this bit lands
  always_comb begin
    res_nx = {s_bit, res_sh[WIDTH-1:1]};
    last   = (cnt == CNT_W'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= next;
  end

  // Next state and handshake outputs
  always_comb begin
    next  = state;
    READY = 1'b0;
    DONE  = 1'b0;
    unique case (state)
      IDLE: begin
        READY = 1'b1;
        if (START) next = RUN;
      end
      RUN: begin
        if (last) next = FIN;
      end
      FIN: begin
        DONE = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // Operand capture, bit stepping and result latch
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      SUM    <= '0;
      C_OUT  <= 1'b0;
    end else begin
      if (state == IDLE && START) begin
        a_sh   <= A;
        res_sh <= '0;
        cnt    <= '0;
`ifdef SERIAL_SUB_EN
        b_sh   <= SUB ? ~B : B;
        carry  <= SUB;
`else
        b_sh   <= B;
        carry  <= 1'b0;
`endif
      end else if (state == RUN) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        res_sh <= res_nx;
        carry  <= c_bit;
        cnt    <= cnt + CNT_W'(1);
        if (last) begin
          SUM   <= res_nx;
          C_OUT <= c_bit;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer.
// Vector table, random ops vs model, corner sequences.
module tb_serial_add_sequencer;

  localparam int W = 3;
  localparam int MASK = (1 << W) - 1;

  logic         CLK;
  logic         RST_N;
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
`ifdef SERIAL_SUB_EN
  logic         SUB;
`endif
  logic         READY;
  logic         DONE;
  logic [W-1:0] SUM;
  logic         C_OUT;

  int pass_cnt = 0;
  int total    = 0;

  serial_add_sequencer #(
    .WIDTH (W),
    .CNT_W (4)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .A     (A),
    .B     (B),
`ifdef SERIAL_SUB_EN
    .SUB   (SUB),
`endif
    .READY (READY),
    .DONE  (DONE),
    .SUM   (SUM),
    .C_OUT (C_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act,
                       input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference: true sum of A and B (or A + ~B + 1)
  function automatic int model(input int a, input int b,
                               input logic sub);
    if (sub) return a + ((~b) & MASK) + 1;
    return a + b;
  endfunction

  // One complete operation from IDLE; returns result
  task automatic run_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic sub,
                        output logic [W-1:0] s,
                        output logic c);
    int n;
    START = 1'b1;
    A = a;
    B = b;
`ifdef SERIAL_SUB_EN
    SUB = sub;
`endif
    step();
    START = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
`ifdef SERIAL_SUB_EN
    SUB = $urandom_range(0, 1) != 0;
`endif
    n = 0;
    while (!DONE && n < 50) begin
      step();
      n++;
    end
    check("latency", n, W);
    s = SUM;
    c = C_OUT;
    step();
    check("ready_after", {30'd0, READY, DONE}, 2);
  endtask

  logic [W-1:0] rs;
  logic         rc;
  int           exp_v;
  int           dones;
  int           pos[$];

  initial begin
    START = 1'b0;
    A = '0;
    B = '0;
`ifdef SERIAL_SUB_EN
    SUB = 1'b0;
`endif
    RST_N = 1'b0;

    tbl.push_back('{3'd3, 3'd5, 1'b0, 3'd0, 1'b1});
    tbl.push_back('{3'd7, 3'd7, 1'b0, 3'd6, 1'b1});
    tbl.push_back('{3'd2, 3'd1, 1'b0, 3'd3, 1'b0});
    tbl.push_back('{3'd4, 3'd1, 1'b0, 3'd5, 1'b0});
    tbl.push_back('{3'd6, 3'd3, 1'b0, 3'd1, 1'b1});
    tbl.push_back('{3'd0, 3'd0, 1'b0, 3'd0, 1'b0});
`ifdef SERIAL_SUB_EN
    tbl.push_back('{3'd5, 3'd3, 1'b1, 3'd2, 1'b1});
    tbl.push_back('{3'd3, 3'd5, 1'b1, 3'd6, 1'b0});
    tbl.push_back('{3'd4, 3'd4, 1'b1, 3'd0, 1'b1});
`endif

    #12;
    check("rst_ready", READY, 1);
    check("rst_done", DONE, 0);
    check("rst_sum", SUM, 0);
    check("rst_cout", C_OUT, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    step();

    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].sub, rs, rc);
      check($sformatf("tbl%0d_sum", i), rs, tbl[i].sum);
      check($sformatf("tbl%0d_cout", i), rc, tbl[i].cout);
    end

    for (int i = 0; i < 25; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rsub;
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_SUB_EN
      rsub = $urandom_range(0, 1) != 0;
`else
      rsub = 1'b0;
`endif
      exp_v = model(ra, rb, rsub);
      run_op(ra, rb, rsub, rs, rc);
      check("rnd_sum", rs, exp_v & MASK);
      check("rnd_cout", rc, (exp_v >> W) & 1);
    end

    // START held high: one op every W+2 cycles
    START = 1'b1;
    A = 3'd1;
    B = 3'd1;
`ifdef SERIAL_SUB_EN
    SUB = 1'b0;
`endif
    dones = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (DONE) begin
        pos.push_back(k);
        check("hold_sum", SUM, 2);
      end
    end
    START = 1'b0;
    check("hold_pulses", pos.size(), 4);
    for (int k = 1; k < pos.size(); k++)
      check("hold_period", pos[k] - pos[k-1], W + 2);
    dones = 0;
    while (!READY && dones < 20) begin
      step();
      dones++;
    end
    check("hold_idle", READY, 1);

    // Back-to-back: first result holds through second RUN
    run_op(3'd4, 3'd1, 1'b0, rs, rc);
    check("b2b1_sum", rs, 5);
    START = 1'b1;
    A = 3'd6;
    B = 3'd3;
    step();
    START = 1'b0;
    A = 3'd0;
    B = 3'd0;
    for (int k = 0; k < W - 1; k++) begin
      check("b2b_hold_sum", SUM, 5);
      check("b2b_hold_cout", C_OUT, 0);
      step();
    end
    check("b2b_hold_ready", READY, 0);
    step();
    check("b2b2_done", DONE, 1);
    check("b2b2_sum", SUM, 1);
    check("b2b2_cout", C_OUT, 1);
    step();

    // Reset in the middle of RUN aborts the op
    run_op(3'd7, 3'd7, 1'b0, rs, rc);
    check("pre_rst_sum", rs, 6);
    START = 1'b1;
    A = 3'd2;
    B = 3'd1;
    step();
    START = 1'b0;
    step();
    #2;
    RST_N = 1'b0;
    #1;
    check("abort_ready", READY, 1);
    check("abort_done", DONE, 0);
    check("abort_sum", SUM, 0);
    check("abort_cout", C_OUT, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (DONE) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_idle", READY, 1);
    check("abort_sum_hold", SUM, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
